// File: rtl/bch_encode_sched.sv
// Round-robin front end for the bit-serial BCH encoder: restarts the encoder,
// streams the granted message MSB-first and collects the serial codeword.
module bch_encode_sched #(
  parameter int N = 15,
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [K-1:0] req0_msg,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [K-1:0] req1_msg,
  output logic         req1_ready,
  output logic         enc_reset,
  output logic         enc_din,
  input  logic         enc_vdin,
  input  logic         enc_dout,
  output logic         cw_valid,
  output logic [N-1:0] cw_data,
  output logic         cw_id,
  input  logic         cw_ready,
  output logic         busy,
  output logic         err,
  output logic [15:0]  frame_count
);
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_DRAIN, S_OUT} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [K-1:0]    msg_q, msg_d;
  logic            id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            cap_en_q, cap_en_d;
  logic [N-1:0]    cw_shift_q, cw_shift_d;
  logic [N-1:0]    cw_data_q, cw_data_d;
  logic            cw_valid_q, cw_valid_d;
  logic            cw_id_q, cw_id_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic gnt_any, gnt_id;

  // Tie goes to the requester the pointer does not name.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b1;
      msg_q         <= '0;
      id_q          <= 1'b0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      cap_en_q      <= 1'b0;
      cw_shift_q    <= '0;
      cw_data_q     <= '0;
      cw_valid_q    <= 1'b0;
      cw_id_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      msg_q         <= msg_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      cap_en_q      <= cap_en_d;
      cw_shift_q    <= cw_shift_d;
      cw_data_q     <= cw_data_d;
      cw_valid_q    <= cw_valid_d;
      cw_id_q       <= cw_id_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_any) state_d = S_START;
      S_START:  state_d = S_DATA;
      S_DATA:   if (cnt_q == '0) state_d = S_PARITY;
      S_PARITY: if (cnt_q == '0) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_OUT;
      S_OUT:    if (cw_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d          = rr_q;
    msg_d         = msg_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    cw_shift_d    = cw_shift_q;
    cw_data_d     = cw_data_q;
    cw_valid_d    = cw_valid_q;
    cw_id_d       = cw_id_q;
    frame_count_d = frame_count_q;
    cap_en_d      = (state_q == S_DATA) || (state_q == S_PARITY);

    // Encoder output lags its input by one cycle, hence the registered enable.
    if (cap_en_q) cw_shift_d = {cw_shift_q[N-2:0], enc_dout};

    case (state_q)
      S_IDLE: if (gnt_any) begin
        rr_d  = gnt_id;
        id_d  = gnt_id;
        msg_d = gnt_id ? req1_msg : req0_msg;
      end
      S_START: cnt_d = CW'(K-1);
      S_DATA: begin
        if (!enc_vdin) err_d = 1'b1;
        cnt_d = (cnt_q == '0) ? CW'(N-K-1) : cnt_q - 1'b1;
      end
      S_PARITY: cnt_d = cnt_q - 1'b1;
      S_DRAIN: begin
        cw_data_d  = cw_shift_d;
        cw_valid_d = 1'b1;
        cw_id_d    = id_q;
      end
      S_OUT: if (cw_ready) begin
        cw_valid_d    = 1'b0;
        frame_count_d = frame_count_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == S_IDLE) && gnt_any && !gnt_id;
    req1_ready = (state_q == S_IDLE) && gnt_any &&  gnt_id;
    enc_reset  = (state_q != S_DATA) && (state_q != S_PARITY);
    enc_din    = (state_q == S_DATA) ? msg_q[cnt_q] : 1'b0;
    busy       = (state_q != S_IDLE);
  end

  assign cw_valid    = cw_valid_q;
  assign cw_data     = cw_data_q;
  assign cw_id       = cw_id_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bch_encode_sched.sv
// Directed bench for bch_encode_sched with a BCH(15,5) serial encoder model
// (g(x) = x^10+x^8+x^5+x^4+x^2+x+1, registered output).
module tb_bch_encode_sched;
  localparam int N = 15;
  localparam int K = 5;
  localparam logic [9:0] GLOW = 10'h137;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [K-1:0]  req0_msg, req1_msg;
  logic          req0_ready, req1_ready;
  logic          enc_reset, enc_din, enc_vdin, enc_dout;
  logic          cw_valid, cw_id, cw_ready, busy, err;
  logic [N-1:0]  cw_data;
  logic [15:0]   frame_count;

  int tests = 0;
  int failed = 0;
  int exp_fc = 0;
  logic vdin_drop = 1'b0;

  always #5 clk = ~clk;

  bch_encode_sched #(.N(N), .K(K)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_msg(req0_msg), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_msg(req1_msg), .req1_ready(req1_ready),
    .enc_reset(enc_reset), .enc_din(enc_din), .enc_vdin(enc_vdin), .enc_dout(enc_dout),
    .cw_valid(cw_valid), .cw_data(cw_data), .cw_id(cw_id), .cw_ready(cw_ready),
    .busy(busy), .err(err), .frame_count(frame_count)
  );

  // Systematic LFSR encoder: K message bits pass through, then 10 parity bits.
  logic [9:0] e_lfsr = '0;
  int         e_cnt = 0;
  logic       e_dout = 1'b0;
  logic       fb;
  assign enc_dout = e_dout;
  assign enc_vdin = ~vdin_drop;

  always @(posedge clk) begin
    if (enc_reset) begin
      e_lfsr <= '0; e_cnt <= 0; e_dout <= 1'b0;
    end else if (e_cnt < K) begin
      fb = enc_din ^ e_lfsr[9];
      e_lfsr <= {e_lfsr[8:0], 1'b0} ^ (fb ? GLOW : 10'h0);
      e_dout <= enc_din;
      e_cnt  <= e_cnt + 1;
    end else begin
      e_dout <= e_lfsr[9];
      e_lfsr <= {e_lfsr[8:0], 1'b0};
      e_cnt  <= e_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Grant at t0, expect cw_valid at t18 with cw_ready high.
  task automatic run_frame(input logic id, input logic [K-1:0] m, input logic [N-1:0] exp,
                           input logic drop);
    int n;
    if (id) begin req1_valid = 1'b1; req1_msg = m; end
    else    begin req0_valid = 1'b1; req0_msg = m; end
    #1;
    chk("grant_ready", id ? req1_ready : req0_ready, 1);
    step(); n = 1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (!cw_valid && n < 40) begin
      step(); n++;
      vdin_drop = drop && (n == 3);
    end
    vdin_drop = 1'b0;
    chk("latency", n, 18);
    chk("cw_data", cw_data, exp);
    chk("cw_id", cw_id, id);
    step(); exp_fc++;
    chk("cw_valid_drop", cw_valid, 0);
    chk("frame_count", frame_count, exp_fc);
  endtask

  logic [3:0]   gseq, cids;
  logic [N-1:0] cdat [4];
  int ng, ncw, cyc;
  logic stable;
  logic [N-1:0] held;

  initial begin
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_msg = '0; req1_msg = '0; cw_ready = 1'b1;
    #3;
    chk("rst_enc_reset", enc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cw_valid", cw_valid, 0);
    chk("rst_cw_data", cw_data, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_err", err, 0);
    step(); step(); reset_n = 1'b1;
    step(); step();
    chk("idle_no_req", busy, 0);

    run_frame(1'b0, 5'b00001, 15'h0537, 1'b0);
    run_frame(1'b0, 5'b00010, 15'h0A6E, 1'b0);
    run_frame(1'b0, 5'b00011, 15'h0F59, 1'b0);
    run_frame(1'b1, 5'b11111, 15'h7FFF, 1'b0);
    run_frame(1'b1, 5'b00000, 15'h0000, 1'b0);
    chk("no_err", err, 0);

    // Both requesters continuously valid.
    req0_msg = 5'b00001; req1_msg = 5'b11111;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    ng = 0; ncw = 0; cyc = 0; gseq = '0; cids = '0;
    while (ncw < 4 && cyc < 200) begin
      if (req0_ready || req1_ready) begin
        if (ng < 4) gseq[ng] = req1_ready;
        ng++;
      end
      if (cw_valid) begin
        cids[ncw] = cw_id; cdat[ncw] = cw_data; ncw++;
        if (ncw == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      step(); cyc++;
    end
    exp_fc += 4;
    chk("rr_grants", ng, 4);
    chk("rr_cws", ncw, 4);
    chk("rr_gseq", gseq, 4'b1010);
    chk("rr_ids", cids, 4'b1010);
    chk("rr_d0", cdat[0], 15'h0537);
    chk("rr_d1", cdat[1], 15'h7FFF);
    chk("rr_d3", cdat[3], 15'h7FFF);
    chk("rr_fc", frame_count, exp_fc);

    // Downstream backpressure in OUT.
    cw_ready = 1'b0;
    req0_valid = 1'b1; req0_msg = 5'b00010; #1;
    step(); req0_valid = 1'b0; cyc = 0;
    while (!cw_valid && cyc < 40) begin step(); cyc++; end
    chk("bp_reached", cw_valid, 1);
    held = cw_data;
    req1_valid = 1'b1; req1_msg = 5'b00011; #1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!cw_valid || cw_data !== held || cw_id !== 1'b0 || req0_ready || req1_ready)
        stable = 1'b0;
      step();
    end
    chk("bp_stable", stable, 1);
    chk("bp_data", cw_data, 15'h0A6E);
    cw_ready = 1'b1;
    step(); exp_fc++;
    cw_ready = 1'b0;
    #1;
    chk("bp_accept_valid", cw_valid, 0);
    chk("bp_next_grant", req1_ready, 1);
    chk("bp_fc", frame_count, exp_fc);
    step(); req1_valid = 1'b0; cw_ready = 1'b1; cyc = 1;
    while (!cw_valid && cyc < 40) begin step(); cyc++; end
    chk("bp2_latency", cyc, 18);
    chk("bp2_data", cw_data, 15'h0F59);
    chk("bp2_id", cw_id, 1);
    step(); exp_fc++;

    // Encoder drops its valid strobe mid-message.
    run_frame(1'b0, 5'b00001, 15'h0537, 1'b1);
    chk("err_set", err, 1);
    run_frame(1'b1, 5'b11111, 15'h7FFF, 1'b0);
    chk("err_sticky", err, 1);

    // Async reset in the middle of DATA.
    req0_valid = 1'b1; req0_msg = 5'b00001; #1;
    step(); req0_valid = 1'b0;
    step(); step(); step();
    chk("mid_busy_pre", busy, 1);
    reset_n = 1'b0; #1;
    chk("mid_busy", busy, 0);
    chk("mid_enc_reset", enc_reset, 1);
    chk("mid_cw_valid", cw_valid, 0);
    chk("mid_cw_data", cw_data, 0);
    chk("mid_fc", frame_count, 0);
    chk("mid_err", err, 0);
    step(); reset_n = 1'b1; exp_fc = 0;
    step();
    run_frame(1'b0, 5'b00011, 15'h0F59, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bch_encode_sched.md
Name: bch_encode_sched

Overview:
Front-end scheduler for the bit-serial BCH encoder. It arbitrates round-robin between two requesters, each presenting a parallel K-bit message with a valid/ready handshake. It restarts the encoder, feeds the granted message into it MSB-first, and collects the N-bit serial codeword into a parallel output register tagged with the requester ID. It sits between message producers and the downstream framer, and the encoder instance lives outside this block.

Parameters:
N, 15, codeword length (encoder N)
K, 5, message length (encoder K); 1 < K < N

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a message
req0_msg  input  K  requester 0 message, bit K-1 sent first
req0_ready  output  1  requester 0 message accepted this cycle
req1_valid  input  1  requester 1 has a message
req1_msg  input  K  requester 1 message
req1_ready  output  1  requester 1 message accepted this cycle
enc_reset  output  1  drives the encoder's synchronous active-high reset
enc_din  output  1  serial data to the encoder
enc_vdin  input  1  encoder input-valid strobe
enc_dout  input  1  encoder serial output (registered, 1-cycle lag)
cw_valid  output  1  codeword available
cw_data  output  N  codeword, bit N-1 = first serial bit
cw_id  output  1  requester that owns cw_data
cw_ready  input  1  downstream accepts the codeword
busy  output  1  state != IDLE
err  output  1  sticky: enc_vdin low during DATA
frame_count  output  16  codewords delivered, wraps at 2^16

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; rr pointer=1, so requester 0 wins the first tie.
  - All outputs 0 except enc_reset=1.
  - cw_data=0, frame_count=0, err=0.
- States: IDLE, START, DATA, PARITY, DRAIN, OUT.
- IDLE:
  - enc_reset=1.
  - If exactly one reqX_valid, grant X. If both valid, grant the requester != rr, then rr<=grant.
  - reqX_ready=1 combinationally for the granted requester in this cycle only; msg and id are latched. Go to START.
  - No valid: stay in IDLE.
- START: 1 cycle, enc_reset=1 (encoder restarts). Bit counter <= K-1. Go to DATA.
- DATA: K cycles, enc_reset=0.
  - enc_din = msg[counter]; counter decrements.
  - If enc_vdin==0 in any DATA cycle, err<=1. err clears only on reset; the frame still completes.
  - At counter==0, counter<=N-K-1 and go to PARITY.
- PARITY: N-K cycles, enc_din=0, counter decrements. At 0 go to DRAIN.
- DRAIN: 1 cycle, go to OUT.
- Capture:
  - cap_en = registered (state==DATA || state==PARITY).
  - When cap_en=1, cw_shift <= {cw_shift[N-2:0], enc_dout}.
  - Exactly N captures, ending in DRAIN.
  - On DRAIN→OUT: cw_data <= final shift value, cw_valid <= 1, cw_id <= latched id.
- OUT:
  - cw_valid=1. cw_data and cw_id are held stable while cw_ready=0.
  - cw_valid && cw_ready: cw_valid<=0, frame_count++ (wrap), go to IDLE.
  - No new grant in OUT. The earliest next grant is the IDLE cycle after acceptance.
- Latency: grant cycle t0, START t1, DATA t2..t(K+1), cw_valid first high at t(N+3). Minimum period is N+4 cycles per codeword with cw_ready held high.
- Requester inputs are ignored outside IDLE. A request deasserted before grant is simply not served.
- reset_n low mid-frame: immediate return to IDLE with reset values. The partial codeword is discarded and cw_valid drops.
- busy=1 in every state except IDLE.

Test Plan:
- N=15, K=5; req0 msg=5'b00001, cw_ready=1 -> cw_data=15'h0537, cw_id=0, cw_valid 1 cycle at t18, frame_count=1.
- req1 msg=5'b11111 -> cw_data=15'h7FFF, cw_id=1; msg=5'b00000 -> cw_data=15'h0000.
- Both valid continuously, messages A to req0 and B to req1 -> grants alternate 0,1,0,1 (first is 0); ready pulses exactly once per grant; 4 codewords with ids 0,1,0,1.
- cw_ready held low 10 cycles in OUT -> cw_valid, cw_data and cw_id stable; no req ready; then 1-cycle cw_ready -> IDLE, next grant the following cycle.
- reset_n pulsed low during DATA -> outputs immediately reset values, enc_reset=1; next frame after release encodes correctly.
- Encoder model forcing enc_vdin=0 in a DATA cycle -> err=1 and stays 1 through later frames until reset; frame still delivered.
